// File: rtl/receiver_memory.sv
// receiver_memory
//   Receive side of the sender/receiver memory pair. Words arrive over a
//   4-phase Req/Ack handshake. Each word is stored at the next sequential
//   address of a DEPTH x DATA_W buffer, and the local host reads words back
//   by address.
//
//   Optional build macro: RX_PARITY_EN enables the even-parity check on
//   incoming words. The ParityErr flag is sticky. The port list is the same
//   with or without the macro.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   Req         sender request; DataIn and ParityIn are stable while high
//   DataIn      word from the sender
//   ParityIn    even-parity bit for DataIn (used only with RX_PARITY_EN)
//   Ack         handshake acknowledge to the sender
//   ReadEnable  host read strobe
//   Address     host read address
//   DataOut     registered read data, one cycle after ReadEnable
//   Clear       synchronous empty; resets the write pointer and Count
//   Count       number of words stored, 0..DEPTH
//   Full        high when Count == DEPTH
//   ParityErr   sticky parity error flag
//
// FSM states
//   IDLE  | wait for Req while not Full; Ack low
//   STORE | single cycle: write word, bump pointer/count, raise Ack
//   ACK   | hold Ack until Req is seen low, then return to IDLE

module receiver_memory #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16   // must equal 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Req,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              ParityIn,
    output logic              Ack,
    input  logic              ReadEnable,
    input  logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] DataOut,
    input  logic              Clear,
    output logic [ADDR_W:0]   Count,
    output logic              Full,
    output logic              ParityErr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    state_t              state_q, state_d;
    logic                ack_q, ack_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [DATA_W-1:0]   dout_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                full;
    logic                store_en;

    assign full     = (count_q == CNT_MAX);
    assign store_en = (state_q == STORE);

    // Handshake FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                // While full, Req is left pending; the sender simply waits.
                if (Req && !full) begin
                    state_d = STORE;
                end
            end
            STORE: begin
                // Req is not looked at here, so a glitch low is ignored.
                ack_d   = 1'b1;
                state_d = ACK;
            end
            ACK: begin
                if (!Req) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Write pointer and fill count. Clear wins over the STORE increment.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (Clear) begin
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (store_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset. The word is written even when Clear coincides
    // with STORE, so a word that was acknowledged always lands in memory.
    always_ff @(posedge clk) begin
        if (store_en) begin
            mem_q[wr_ptr_q] <= DataIn;
        end
    end

    // Registered read. A read of the address being written in the same
    // cycle returns the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (ReadEnable) begin
            dout_q <= mem_q[Address];
        end
    end

`ifdef RX_PARITY_EN
    logic perr_q, perr_d;

    always_comb begin
        perr_d = perr_q;
        if (Clear) begin
            perr_d = 1'b0;
        end else if (store_en && (^{DataIn, ParityIn})) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign ParityErr = perr_q;
`else
    logic unused_parity_in;
    assign unused_parity_in = ParityIn;
    assign ParityErr        = 1'b0;
`endif

    assign Ack     = ack_q;
    assign DataOut = dout_q;
    assign Count   = count_q;
    assign Full    = full;

endmodule

// File: tb/tb_receiver_memory.sv
module tb_receiver_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Req;
    logic [15:0] DataIn;
    logic        ParityIn;
    logic        Ack;
    logic        ReadEnable;
    logic [3:0]  Address;
    logic [15:0] DataOut;
    logic        Clear;
    logic [4:0]  Count;
    logic        Full;
    logic        ParityErr;

    int n_cmp = 0;
    int n_err = 0;

`ifdef RX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    receiver_memory dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Req        (Req),
        .DataIn     (DataIn),
        .ParityIn   (ParityIn),
        .Ack        (Ack),
        .ReadEnable (ReadEnable),
        .Address    (Address),
        .DataOut    (DataOut),
        .Clear      (Clear),
        .Count      (Count),
        .Full       (Full),
        .ParityErr  (ParityErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  exp_count;
        logic        exp_full;
    } vec_t;

    vec_t vt [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full 4-phase transfer with cycle-exact Ack checks.
    task automatic do_xfer(input logic [15:0] d, input logic p, input logic [4:0] exp_cnt,
                           input string tag);
        @(negedge clk);
        Req = 1'b1; DataIn = d; ParityIn = p;
        @(posedge clk); @(negedge clk);
        check({tag, "_ack_early"}, 32'(Ack), 32'd0);
        @(posedge clk); @(negedge clk);
        check({tag, "_ack_hi"}, 32'(Ack), 32'd1);
        check({tag, "_count"}, 32'(Count), 32'(exp_cnt));
        Req = 1'b0;
        @(posedge clk); @(negedge clk);
        check({tag, "_ack_lo"}, 32'(Ack), 32'd0);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [15:0] exp, input string tag);
        @(negedge clk);
        ReadEnable = 1'b1; Address = a;
        @(posedge clk); @(negedge clk);
        ReadEnable = 1'b0;
        check(tag, 32'(DataOut), 32'(exp));
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        Clear = 1'b1;
        @(posedge clk); @(negedge clk);
        Clear = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            vt[i].data      = 16'h0100 + 16'(i);
            vt[i].exp_count = 5'(i + 1);
            vt[i].exp_full  = (i == 15);
        end

        rst_n = 1'b0; Req = 1'b0; DataIn = '0; ParityIn = 1'b0;
        ReadEnable = 1'b0; Address = '0; Clear = 1'b0;

        // Reset state
        #12;
        check("rst_ack", 32'(Ack), 32'd0);
        check("rst_count", 32'(Count), 32'd0);
        check("rst_dout", 32'(DataOut), 32'd0);
        check("rst_full", 32'(Full), 32'd0);
        check("rst_perr", 32'(ParityErr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single transfer and readback; DataOut holds while ReadEnable low
        do_xfer(16'hA5A5, 1'b0, 5'd1, "single");
        do_read(4'd0, 16'hA5A5, "single_read");
        @(negedge clk);
        Address = 4'd7;
        @(posedge clk); @(negedge clk);
        check("dout_hold", 32'(DataOut), 32'hA5A5);

        // Fill to full from the vector table, then read everything back
        pulse_clear();
        check("clear_count", 32'(Count), 32'd0);
        for (int i = 0; i < 16; i++) begin
            do_xfer(vt[i].data, 1'b0, vt[i].exp_count, $sformatf("fill%0d", i));
            check($sformatf("fill%0d_full", i), 32'(Full), 32'(vt[i].exp_full));
        end
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i), vt[i].data, $sformatf("fill_read%0d", i));
        end

        // 17th request stalls while full; reads still work
        @(negedge clk);
        Req = 1'b1; DataIn = 16'h0BAD;
        begin
            int stall_bad = 0;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); @(negedge clk);
                if (Ack !== 1'b0 || Count !== 5'd16) stall_bad++;
            end
            check("stall_ack_count", 32'(stall_bad), 32'd0);
        end
        do_read(4'd3, 16'h0103, "read_while_full");

        // Clear releases the stall; pending word lands at address 0
        @(negedge clk);
        Clear = 1'b1;
        @(posedge clk); @(negedge clk);
        Clear = 1'b0;
        check("rel_count0", 32'(Count), 32'd0);
        check("rel_full0", 32'(Full), 32'd0);
        check("rel_ack0", 32'(Ack), 32'd0);
        @(posedge clk); @(negedge clk);
        check("rel_ack_store", 32'(Ack), 32'd0);
        @(posedge clk); @(negedge clk);
        check("rel_ack1", 32'(Ack), 32'd1);
        check("rel_count1", 32'(Count), 32'd1);
        Req = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rel_ack_lo", 32'(Ack), 32'd0);
        do_read(4'd0, 16'h0BAD, "rel_read0");
        do_read(4'd1, 16'h0101, "mem_kept1");

        // Advance wr_ptr to 5, then Clear coincident with STORE
        for (int k = 1; k <= 4; k++) begin
            do_xfer(16'h4000 + 16'(k), 1'b0, 5'(k + 1), $sformatf("pre%0d", k));
        end
        @(negedge clk);
        Req = 1'b1; DataIn = 16'h1234;
        @(posedge clk); @(negedge clk);
        Clear = 1'b1;
        @(posedge clk); @(negedge clk);
        Clear = 1'b0;
        check("cs_ack", 32'(Ack), 32'd1);
        check("cs_count", 32'(Count), 32'd0);
        Req = 1'b0;
        @(posedge clk); @(negedge clk);
        check("cs_ack_lo", 32'(Ack), 32'd0);
        do_read(4'd5, 16'h1234, "cs_read5");
        do_xfer(16'h5555, 1'b0, 5'd1, "cs_ptr0");
        do_read(4'd0, 16'h5555, "cs_read0");

        // Read-before-write at the address being stored (wr_ptr = 1)
        @(negedge clk);
        Req = 1'b1; DataIn = 16'h7777;
        @(posedge clk); @(negedge clk);
        ReadEnable = 1'b1; Address = 4'd1;
        @(posedge clk); @(negedge clk);
        ReadEnable = 1'b0;
        check("rbw_old", 32'(DataOut), 32'h4001);
        check("rbw_ack", 32'(Ack), 32'd1);
        Req = 1'b0;
        @(posedge clk); @(negedge clk);
        do_read(4'd1, 16'h7777, "rbw_new");

        // Parity: good, bad, good; sticky until Clear
        pulse_clear();
        do_xfer(16'h0007, 1'b1, 5'd1, "par_good");
        check("perr_after_good", 32'(ParityErr), 32'd0);
        do_xfer(16'h0001, 1'b0, 5'd2, "par_bad");
        check("perr_after_bad", 32'(ParityErr), 32'(PAR_EN));
        do_xfer(16'h0003, 1'b0, 5'd3, "par_good2");
        check("perr_sticky", 32'(ParityErr), 32'(PAR_EN));
        do_read(4'd1, 16'h0001, "par_bad_stored");
        pulse_clear();
        check("perr_cleared", 32'(ParityErr), 32'd0);

        // Reset asserted while in ACK
        do_xfer(16'h2222, 1'b0, 5'd1, "pre_rst");
        do_read(4'd0, 16'h2222, "pre_rst_read");
        @(negedge clk);
        Req = 1'b1; DataIn = 16'hCCCC;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("mid_ack", 32'(Ack), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ack", 32'(Ack), 32'd0);
        check("arst_count", 32'(Count), 32'd0);
        check("arst_dout", 32'(DataOut), 32'd0);
        Req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_xfer(16'h9999, 1'b0, 5'd1, "post_rst");
        do_read(4'd0, 16'h9999, "post_rst_read0");
        do_read(4'd1, 16'hCCCC, "post_rst_read1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/receiver_memory.md
Name: receiver_memory

Overview:
- Receive-side counterpart of the sender memory.
- Accepts 16-bit words from the sender over a 4-phase Req/Ack handshake and stores them at sequential addresses in a 16x16 buffer.
- The local host reads stored words by address.
- Tracks fill level, stalls the handshake when full, and is emptied by a synchronous Clear.

Parameters:
- DATA_W, 16, word width.
- ADDR_W, 4, address width.
- DEPTH, 16, number of words; must equal 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- Req  input  1  sender request; DataIn and ParityIn are stable while high.
- DataIn  input  DATA_W  word from sender.
- ParityIn  input  1  even-parity bit for DataIn; used only with RX_PARITY_EN.
- Ack  output  1  handshake acknowledge to sender.
- ReadEnable  input  1  host read strobe.
- Address  input  ADDR_W  host read address.
- DataOut  output  DATA_W  registered read data.
- Clear  input  1  synchronous empty: write pointer and count go to 0.
- Count  output  ADDR_W+1  words stored, 0..DEPTH.
- Full  output  1  high when Count == DEPTH.
- ParityErr  output  1  sticky parity error flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; Ack=0; DataOut=0; wr_ptr=0; Count=0; ParityErr=0.
  - Memory contents are not reset.
  - Reset asserted mid-handshake aborts the transfer; no partial write.
- FSM, 2-bit encoding: IDLE=0, STORE=1, ACK=2; code 3 → IDLE.
  - IDLE: if Req && !Full, go to STORE; else stay. Ack=0.
  - STORE (exactly one cycle): mem[wr_ptr] <= DataIn; wr_ptr <= wr_ptr+1 (wraps 15→0); Count <= Count+1; Ack <= 1; go to ACK.
  - ACK: hold Ack=1 while Req=1. When Req is sampled 0, Ack <= 0 and go to IDLE.
- Handshake latency:
  - Req first sampled high at edge N → write at edge N+1; Ack high after edge N+1.
  - Req sampled low at edge M → Ack low after edge M.
  - Minimum transfer is 3 cycles.
- Full:
  - Count==DEPTH → Full=1. Req is left unacknowledged: FSM stays in IDLE and Ack stays 0.
  - No overwrite and no data loss; the sender simply waits.
- Clear:
  - Any state: wr_ptr <= 0, Count <= 0 at the next edge. Clear has priority over the STORE increment.
  - Clear coincident with STORE: the word is still written to the old wr_ptr, but pointer and count end at 0; the handshake completes normally.
  - Clear does not touch memory, DataOut or Ack. It also clears ParityErr.
- Read:
  - ReadEnable high at edge N → DataOut = mem[Address] after edge N (1-cycle registered latency).
  - DataOut holds its value while ReadEnable is low.
  - Read of the address being written in STORE in the same cycle returns the old contents (read-before-write).
  - Reads are never blocked by the handshake or by Full.
- Width rules:
  - Count is ADDR_W+1 bits and never exceeds DEPTH.
  - wr_ptr is ADDR_W bits and wraps modulo DEPTH.
- Req glitches: Req dropping to 0 while in STORE is ignored; ACK then sees Req=0 and returns to IDLE.

Optional Feature:
- Macro: RX_PARITY_EN.
- Defined:
  - In STORE, compute ^{DataIn, ParityIn}. A nonzero result sets ParityErr=1 (sticky until Clear or reset).
  - The word is still stored and acknowledged.
- Undefined:
  - ParityIn is ignored and ParityErr is tied to 0.
  - The port list is identical in both builds.

Test Plan:
- Single transfer: after reset, Req=1 with DataIn=16'hA5A5. Expect Ack=1 two edges later, mem[0]=16'hA5A5 and Count=1. Drop Req; Ack=0 on the next edge. Then ReadEnable with Address=0 gives DataOut=16'hA5A5 one cycle later.
- Fill to full: 16 transfers of DataIn=16'h0100+i. Expect Count=16 and Full=1. A 17th Req stays high for 20 cycles with Ack=0 throughout. Read addresses 0..15 return 16'h0100..16'h010F.
- Clear releases a stall: with the 17th Req pending, pulse Clear. Expect Count=0, Full=0, then the pending word is written to address 0 with Count=1 and Ack=1.
- Clear during STORE: Clear asserted in the STORE cycle of DataIn=16'h1234 at wr_ptr=5. Expect mem[5]=16'h1234, Count=0, wr_ptr=0, and the handshake completes.
- Reset mid-handshake: drop rst_n while in ACK. Expect Ack=0, Count=0 and DataOut=0 immediately, with no clock edge needed. After release, a new transfer writes to address 0.
- RX_PARITY_EN build: DataIn=16'h0001 with ParityIn=0 sets ParityErr=1 and the word is still stored. A following good word (16'h0003, ParityIn=0) leaves ParityErr=1; Clear returns it to 0. In the non-macro build, ParityErr stays 0 throughout.
